// File: rtl/tpgen_seq.sv
// tpgen_seq: parametrised timepulse sequencer.
// Turns CLOCK into a one-hot phase ring (PH) inside a one-hot timepulse ring
// (T); one trip around T is one memory cycle of NPULSE*DIV clocks. It also
// produces the RT/WT strobes, the end-of-cycle strobe T12SET, the GOJAM
// restart cycle and a completed-cycle counter MCYC.
// Optional feature: define TPGEN_MSTP_EN to enable the monitor stop /
// single-step HOLD state driven by MSTP and MSTRTP. Without it the sequencer
// only alternates between RUN and GOJ, and STOP is tied low.
module tpgen_seq #(
  parameter int NPULSE = 12,
  parameter int DIV    = 2,
  parameter int RT_PH  = 0,
  parameter int WT_PH  = 1,
  parameter int CW     = 16
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              GOJ1,
  input  logic              MSTP,
  input  logic              MSTRTP,
  output logic [NPULSE-1:0] T,
  output logic [DIV-1:0]    PH,
  output logic              RT,
  output logic              WT,
  output logic              T12SET,
  output logic              GOJAM,
  output logic              STOP,
  output logic [CW-1:0]     MCYC
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_GOJ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [NPULSE-1:0] T_FIRST  = NPULSE'(1);
  localparam logic [DIV-1:0]    PH_FIRST = DIV'(1);

  state_t            state_q, state_d;
  logic [NPULSE-1:0] t_q, t_d;
  logic [DIV-1:0]    ph_q, ph_d;
  logic [CW-1:0]     mcyc_q, mcyc_d;
  logic              pend_q, pend_d;

  logic              stop_w;
  logic              last_clock;
  logic              goj_req;

`ifdef TPGEN_MSTP_EN
  logic              strt_q, strt_d;
  logic              strt_prev_q, strt_prev_d;
  logic              strt_edge;

  // MSTRTP is registered twice so the single-step release reacts to a clean,
  // registered rising edge rather than to the raw input level.
  always_comb begin
    strt_d      = MSTRTP;
    strt_prev_d = strt_q;
    strt_edge   = strt_q & ~strt_prev_q;
  end

  assign stop_w = (state_q == S_HOLD);
`else
  logic              unused_mon;

  assign unused_mon = MSTP ^ MSTRTP;
  assign stop_w     = 1'b0;
`endif

  // The last clock of a memory cycle is the top timepulse in its top phase;
  // a restart request is either already pending or arriving this very clock.
  assign last_clock = t_q[NPULSE-1] & ph_q[DIV-1];
  assign goj_req    = pend_q | GOJ1;

  // Next-state logic: advance the rings while running, decide the next cycle
  // type at the cycle boundary, and handle the frozen HOLD state.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    ph_d    = ph_q;
    mcyc_d  = mcyc_q;
    pend_d  = goj_req;

    case (state_q)
      S_RUN, S_GOJ: begin
        if (ph_q[DIV-1]) begin
          ph_d = PH_FIRST;
          if (t_q[NPULSE-1]) begin
            t_d    = T_FIRST;
            mcyc_d = mcyc_q + CW'(1);
          end else begin
            t_d = {t_q[NPULSE-2:0], t_q[NPULSE-1]};
          end
        end else begin
          ph_d = {ph_q[DIV-2:0], ph_q[DIV-1]};
        end

        if (last_clock) begin
          pend_d = 1'b0;
          if (goj_req) begin
            state_d = S_GOJ;
`ifdef TPGEN_MSTP_EN
          end else if (MSTP) begin
            state_d = S_HOLD;
`endif
          end else begin
            state_d = S_RUN;
          end
        end
      end

`ifdef TPGEN_MSTP_EN
      S_HOLD: begin
        pend_d = 1'b0;
        if (GOJ1) begin
          state_d = S_GOJ;
        end else if (strt_edge || !MSTP) begin
          state_d = S_RUN;
        end
      end
`endif

      default: begin
        state_d = S_GOJ;
        t_d     = T_FIRST;
        ph_d    = PH_FIRST;
        pend_d  = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset into a restart cycle at T01/PH0.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= S_GOJ;
      t_q     <= T_FIRST;
      ph_q    <= PH_FIRST;
      mcyc_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      ph_q    <= ph_d;
      mcyc_q  <= mcyc_d;
      pend_q  <= pend_d;
    end
  end

`ifdef TPGEN_MSTP_EN
  // MSTRTP edge-detect history, cleared by reset so a held-high MSTRTP does
  // not look like a fresh edge afterwards.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      strt_q      <= 1'b0;
      strt_prev_q <= 1'b0;
    end else begin
      strt_q      <= strt_d;
      strt_prev_q <= strt_prev_d;
    end
  end
`endif

  // Outputs are the registered rings or single-level decodes of them; the
  // strobes are masked while frozen in HOLD.
  always_comb begin
    T      = t_q;
    PH     = ph_q;
    MCYC   = mcyc_q;
    STOP   = stop_w;
    GOJAM  = (state_q == S_GOJ);
    RT     = ph_q[RT_PH] & ~stop_w;
    WT     = ph_q[WT_PH] & ~stop_w;
    T12SET = last_clock & ~stop_w;
  end

endmodule

// File: tb/tb_tpgen_seq.sv
// tb_tpgen_seq: two tpgen_seq instances (default shape, and a 5x4 shape with
// a 2-bit cycle counter) share one directed stimulus stream. A cycle-position
// model predicts every output each clock; literal checks pin key instants.
module tb_tpgen_seq;

  localparam int A_NP = 12, A_DV = 2, A_RP = 0, A_WP = 1, A_CW = 16;
  localparam int B_NP = 5,  B_DV = 4, B_RP = 1, B_WP = 3, B_CW = 2;

`ifdef TPGEN_MSTP_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, goj1, mstp, mstrtp;

  logic [A_NP-1:0] a_t;
  logic [A_DV-1:0] a_ph;
  logic            a_rt, a_wt, a_t12, a_gojam, a_stop;
  logic [A_CW-1:0] a_mcyc;

  logic [B_NP-1:0] b_t;
  logic [B_DV-1:0] b_ph;
  logic            b_rt, b_wt, b_t12, b_gojam, b_stop;
  logic [B_CW-1:0] b_mcyc;

  always #5 clk = ~clk;

  tpgen_seq #(.NPULSE(A_NP), .DIV(A_DV), .RT_PH(A_RP), .WT_PH(A_WP), .CW(A_CW)) dut_a (
    .CLOCK(clk), .RESET(reset), .GOJ1(goj1), .MSTP(mstp), .MSTRTP(mstrtp),
    .T(a_t), .PH(a_ph), .RT(a_rt), .WT(a_wt), .T12SET(a_t12),
    .GOJAM(a_gojam), .STOP(a_stop), .MCYC(a_mcyc)
  );

  tpgen_seq #(.NPULSE(B_NP), .DIV(B_DV), .RT_PH(B_RP), .WT_PH(B_WP), .CW(B_CW)) dut_b (
    .CLOCK(clk), .RESET(reset), .GOJ1(goj1), .MSTP(mstp), .MSTRTP(mstrtp),
    .T(b_t), .PH(b_ph), .RT(b_rt), .WT(b_wt), .T12SET(b_t12),
    .GOJAM(b_gojam), .STOP(b_stop), .MCYC(b_mcyc)
  );

  int passCount  = 0;
  int checkCount = 0;

  // Shared comparison: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: actual=%0d required=%0d (t=%0t)", name, actual, expected, $time);
  endtask

  // Model: position inside the memory cycle plus cycle type per instance.
  int NPv[2] = '{A_NP, B_NP};
  int DVv[2] = '{A_DV, B_DV};
  int RPv[2] = '{A_RP, B_RP};
  int WPv[2] = '{A_WP, B_WP};
  int CWv[2] = '{A_CW, B_CW};
  int m_pos[2];
  int m_mcyc[2];
  bit m_goj[2];
  bit m_hold[2];
  bit m_pend[2];
  bit m_valid = 1'b0;
  bit s1 = 1'b0, s2 = 1'b0, m_edge;

  task automatic modelStep(input int i, input bit edgeSeen);
    int last;
    last = NPv[i] * DVv[i] - 1;
    if (m_hold[i]) begin
      m_pend[i] = 1'b0;
      if (goj1) begin
        m_hold[i] = 1'b0; m_goj[i] = 1'b1;
      end else if (edgeSeen || !mstp) begin
        m_hold[i] = 1'b0; m_goj[i] = 1'b0;
      end
    end else if (m_pos[i] == last) begin
      m_pos[i]  = 0;
      m_mcyc[i] = (m_mcyc[i] + 1) % (1 << CWv[i]);
      if (m_pend[i] || goj1) m_goj[i] = 1'b1;
      else if (HOLD_EN && mstp) begin
        m_hold[i] = 1'b1; m_goj[i] = 1'b0;
      end else m_goj[i] = 1'b0;
      m_pend[i] = 1'b0;
    end else begin
      m_pos[i]++;
      if (goj1) m_pend[i] = 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      m_edge = s1 && !s2;
      if (reset === 1'b1) begin
        for (int i = 0; i < 2; i++) begin
          m_pos[i] = 0; m_mcyc[i] = 0; m_goj[i] = 1'b1; m_hold[i] = 1'b0; m_pend[i] = 1'b0;
        end
        s1 = 1'b0; s2 = 1'b0; m_valid = 1'b1;
      end else if (m_valid) begin
        for (int i = 0; i < 2; i++) modelStep(i, m_edge);
        s2 = s1; s1 = mstrtp;
      end
    end
  end

  task automatic compareInst(input string p, input int i,
                             input logic [31:0] t, input logic [31:0] ph,
                             input logic rt, input logic wt, input logic t12,
                             input logic gojam, input logic stop, input logic [31:0] mcyc);
    int last, phIdx;
    last  = NPv[i] * DVv[i] - 1;
    phIdx = m_pos[i] % DVv[i];
    checkOutput({p, ".T"},      t,     1 << (m_pos[i] / DVv[i]));
    checkOutput({p, ".PH"},     ph,    1 << phIdx);
    checkOutput({p, ".RT"},     rt,    32'(!m_hold[i] && phIdx == RPv[i]));
    checkOutput({p, ".WT"},     wt,    32'(!m_hold[i] && phIdx == WPv[i]));
    checkOutput({p, ".T12SET"}, t12,   32'(!m_hold[i] && m_pos[i] == last));
    checkOutput({p, ".GOJAM"},  gojam, 32'(m_goj[i]));
    checkOutput({p, ".STOP"},   stop,  32'(m_hold[i]));
    checkOutput({p, ".MCYC"},   mcyc,  m_mcyc[i]);
  endtask

  // Single compare process: every clock after the first reset, both
  // instances are held against the model away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        compareInst("A", 0, 32'(a_t), 32'(a_ph), a_rt, a_wt, a_t12, a_gojam, a_stop, 32'(a_mcyc));
        compareInst("B", 1, 32'(b_t), 32'(b_ph), b_rt, b_wt, b_t12, b_gojam, b_stop, 32'(b_mcyc));
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic g, input logic ms, input logic mst);
    reset = r; goj1 = g; mstp = ms; mstrtp = mst;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  int bMcycExp[5] = '{1, 2, 3, 0, 1};
  int gojFirst, gojLast, gojCount, k;

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    gojFirst = -1; gojLast = -1; gojCount = 0;

    // Clocks 0..110 after reset: reset values, T walk, first boundary,
    // restart-cycle timing and the 2-bit counter wrap.
    for (int n = 0; n <= 110; n++) begin
      if (n == 0) begin
        checkOutput("lit.A.reset.PH", a_ph, 1);
        checkOutput("lit.A.reset.RT", a_rt, 1);
        checkOutput("lit.A.reset.WT", a_wt, 0);
        checkOutput("lit.A.reset.STOP", a_stop, 0);
        checkOutput("lit.A.reset.MCYC", a_mcyc, 0);
        checkOutput("lit.B.reset.RT", b_rt, 0);
      end
      if (n < 24) begin
        checkOutput("lit.A.Twalk", a_t, 1 << (n / 2));
        checkOutput("lit.A.GOJAM0", a_gojam, 1);
        checkOutput("lit.A.T12SET", a_t12, 32'(n == 23));
      end
      if (n == 24) begin
        checkOutput("lit.A.MCYC1", a_mcyc, 1);
        checkOutput("lit.A.GOJAMfall", a_gojam, 0);
        checkOutput("lit.A.Twrap", a_t, 1);
      end
      if (n <= 24) begin
        checkOutput("lit.B.T12SET", b_t12, 32'(n == 19));
        checkOutput("lit.B.RT", b_rt, 32'(n % 4 == 1));
        checkOutput("lit.B.WT", b_wt, 32'(n % 4 == 3));
      end
      if (n > 0 && n <= 100 && n % 20 == 0)
        checkOutput("lit.B.MCYCwrap", b_mcyc, bMcycExp[n / 20 - 1]);
      if (n >= 33 && a_gojam === 1'b1) begin
        if (gojFirst < 0) gojFirst = n;
        gojLast = n;
        gojCount++;
      end
      goj1 = (n == 32 || n == 58);
      @(negedge clk);
    end
    goj1 = 1'b0;
    checkOutput("lit.A.GOJrise", gojFirst, 48);
    checkOutput("lit.A.GOJlast", gojLast, 95);
    checkOutput("lit.A.GOJlen", gojCount, 48);

`ifdef TPGEN_MSTP_EN
    // Monitor stop at the next boundary, then one single-step cycle.
    mstp = 1'b1;
    k = 0;
    while (a_stop !== 1'b1 && k < 60) begin @(negedge clk); k++; end
    checkOutput("lit.A.enterHOLD", a_stop, 1);
    checkOutput("lit.A.HOLD.T", a_t, 1);
    checkOutput("lit.A.HOLD.MCYC", a_mcyc, 5);
    repeat (5) @(negedge clk);
    checkOutput("lit.A.HOLD.frozenMCYC", a_mcyc, 5);
    checkOutput("lit.A.HOLD.frozenT12", a_t12, 0);
    mstrtp = 1'b1;
    @(negedge clk);
    mstrtp = 1'b0;
    checkOutput("lit.A.releaseLatency", a_stop, 1);
    @(negedge clk);
    k = 0;
    while (a_stop === 1'b0 && k < 40) begin k++; @(negedge clk); end
    checkOutput("lit.A.stepLen", k, 24);
    checkOutput("lit.A.stepMCYC", a_mcyc, 6);
    checkOutput("lit.A.stepSTOP", a_stop, 1);

    // Restart request while held.
    repeat (3) @(negedge clk);
    goj1 = 1'b1;
    @(negedge clk);
    goj1 = 1'b0;
    checkOutput("lit.A.HOLDgoj.STOP", a_stop, 0);
    checkOutput("lit.A.HOLDgoj.GOJAM", a_gojam, 1);
    checkOutput("lit.A.HOLDgoj.T", a_t, 1);
    checkOutput("lit.A.HOLDgoj.MCYC", a_mcyc, 6);

    // Restart request and stop request at the same boundary.
    k = 0;
    while (a_t12 !== 1'b1 && k < 30) begin @(negedge clk); k++; end
    checkOutput("lit.A.boundarySeen", a_t12, 1);
    goj1 = 1'b1;
    @(negedge clk);
    goj1 = 1'b0;
    checkOutput("lit.A.gojBeatsStop.GOJAM", a_gojam, 1);
    checkOutput("lit.A.gojBeatsStop.STOP", a_stop, 0);
    mstp = 1'b0;
    repeat (30) @(negedge clk);

    // Reset while held.
    mstp = 1'b1;
    k = 0;
    while (a_stop !== 1'b1 && k < 60) begin @(negedge clk); k++; end
    checkOutput("lit.A.reHOLD", a_stop, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mstp = 1'b0;
    checkOutput("lit.A.resetHOLD.STOP", a_stop, 0);
    checkOutput("lit.A.resetHOLD.GOJAM", a_gojam, 1);
    checkOutput("lit.A.resetHOLD.MCYC", a_mcyc, 0);
`endif

    // Reset in the middle of a cycle at T07.
    k = 0;
    while (a_t !== 12'd64 && k < 30) begin @(negedge clk); k++; end
    checkOutput("lit.A.reachT07", a_t, 64);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("lit.A.midReset.T", a_t, 1);
    checkOutput("lit.A.midReset.PH", a_ph, 1);
    checkOutput("lit.A.midReset.MCYC", a_mcyc, 0);
    checkOutput("lit.A.midReset.GOJAM", a_gojam, 1);
    checkOutput("lit.B.midReset.MCYC", b_mcyc, 0);
    repeat (30) @(negedge clk);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/tpgen_seq.md
# tpgen_seq

Parametrised timepulse sequencer: divides CLOCK into a one-hot phase ring (PH) and a one-hot timepulse ring (T) that together define one memory cycle of NPULSE×DIV clocks. It also produces RT/WT strobes and an end-of-cycle strobe, and owns the GOJAM restart cycle and the monitor stop/single-step hold. Sits directly below the clock divider and feeds the control, memory-timing and monitor blocks; it replaces the fixed 12-pulse timer with configurable pulse count, phase depth and strobe placement.

## Interface
Parameters:
- NPULSE, 12, timepulses per memory cycle (≥2)
- DIV, 2, CLOCK cycles per timepulse (≥2)
- RT_PH, 0, phase index driving RT (<DIV)
- WT_PH, 1, phase index driving WT (<DIV)
- CW, 16, width of memory-cycle counter (≥1)

Ports:
- CLOCK  in  1  sole clock, all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- GOJ1  in  1  restart request, level, sampled every clock
- MSTP  in  1  monitor stop request (used only with TPGEN_MSTP_EN)
- MSTRTP  in  1  monitor start; rising edge releases one memory cycle (TPGEN_MSTP_EN)
- T  out  NPULSE  one-hot timepulse, bit 0 = T01
- PH  out  DIV  one-hot phase within current timepulse
- RT  out  1  PH[RT_PH] while not STOP
- WT  out  1  PH[WT_PH] while not STOP
- T12SET  out  1  high in last clock of memory cycle: T[NPULSE-1] & PH[DIV-1] & !STOP
- GOJAM  out  1  restart cycle in progress
- STOP  out  1  sequencer frozen in HOLD
- MCYC  out  CW  completed memory cycles, wraps modulo 2^CW

## Operation
- States: RUN, GOJ, HOLD. Reset → GOJ.
- Reset values: T=1, PH=1, RT=(RT_PH==0), WT=(WT_PH==0), T12SET=0, GOJAM=1, STOP=0, MCYC=0, pending-GOJ=0.
- PH rotates left one bit per clock in RUN/GOJ; on PH[DIV-1], PH→bit0 and T rotates left; on T12SET, T→T01 and MCYC increments (wrap to 0).
- GOJ1 high on any clock sets pending-GOJ. At each cycle boundary (clock with T12SET), if pending-GOJ: state→GOJ, clear pending. Otherwise from GOJ: state→RUN.
- GOJ lasts exactly NPULSE×DIV clocks; T/PH/MCYC run normally; GOJAM=1 throughout. GOJ1 during GOJ re-sets pending, extending GOJ by one whole cycle.
- HOLD (macro only): at T12SET with MSTP=1 and no pending-GOJ, next state HOLD with T=T01, PH=bit0, MCYC incremented; T, PH, MCYC frozen; STOP=1; RT/WT/T12SET forced 0.
- In HOLD: MSTRTP rising edge or MSTP=0 → RUN next clock from T01/PH0. With MSTP still 1, stops again at next T12SET (single step = one memory cycle).
- GOJ1 in HOLD: next clock → GOJ at T01/PH0, STOP=0. GOJ beats MSTP at the same boundary.
- RESET overrides everything on any clock, including mid-cycle and in HOLD.

## Timing
- Memory cycle = NPULSE×DIV clocks; defaults: 24 clocks.
- First T12SET after reset at clock NPULSE×DIV−1 (0-based); GOJAM falls on the following edge.
- GOJ1 latency: GOJAM starts at the next cycle boundary (0 to NPULSE×DIV clocks later), never mid-cycle except from HOLD (1 clock).
- MSTRTP edge detect is registered: release occurs 1 clock after edge sampling; edges arriving outside HOLD are ignored.
- All outputs registered or single-level decode of registered state; no input-to-output combinational path.

## Configuration
- TPGEN_MSTP_EN defined: HOLD state, MSTP and MSTRTP active as above.
- Undefined: HOLD unreachable, STOP tied 0, MSTP/MSTRTP ignored; sequencer runs continuously (RUN/GOJ only).

## Test plan
- Reset 3 clocks, release, defaults → GOJAM=1 for clocks 0–23, T12SET at clock 23, MCYC=1 at clock 24, GOJAM=0 at clock 24; T walks 1,2,4…2048, each 2 clocks.
- NPULSE=5, DIV=4, RT_PH=1, WT_PH=3 → T12SET every 20 clocks, RT high on clocks ≡1 mod 4, WT on ≡3 mod 4.
- GOJ1 one-clock pulse at T05 of a RUN cycle → GOJAM rises at next T01, lasts exactly 24 clocks; second pulse during GOJ → 48 clocks total.
- (macro) MSTP=1 from RUN → STOP=1 after T12SET, T=1, MCYC frozen; MSTRTP pulse → exactly one 24-clock cycle, MCYC+1, STOP again.
- (macro) GOJ1 while in HOLD → STOP=0 and GOJAM=1 next clock, T=T01; GOJ1 and MSTP both at boundary → GOJ, no HOLD.
- CW=2, run 5 cycles → MCYC sequence 1,2,3,0,1; RESET asserted at T07 → next clock T=1, PH=1, MCYC=0, GOJAM=1.
